// File: rtl/tone_cfg_ctrl_pkg.sv
// Shared types and constants for the tone threshold configuration block.
// Holds the FSM state encoding, register address map and reset defaults.
package tone_cfg_ctrl_pkg;

    localparam int NUM_CH   = 6;
    localparam int NUM_REGS = 12;

    localparam logic [3:0] ADDR_THD_LEV_BASE  = 4'd0;
    localparam logic [3:0] ADDR_BITS_THD_BASE = 4'd6;
    localparam logic [3:0] ADDR_RSVD_BASE     = 4'd12;

    // Register values are two's-complement 16-bit quantities.
    localparam logic [15:0] THD_LEV_DEF   = 16'd300;
    localparam logic [15:0] THD_LEV_2_DEF = 16'd250;
    localparam logic [15:0] BITS_THD_DEF  = 16'd10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_APPLY      = 2'd2,
        ST_ACK        = 2'd3
    } tone_state_e;

    function automatic logic [15:0] reg_default(input logic [3:0] idx);
        logic [15:0] val;
        if (idx == ADDR_THD_LEV_BASE + 4'd2) begin
            val = THD_LEV_2_DEF;
        end else if (idx < ADDR_BITS_THD_BASE) begin
            val = THD_LEV_DEF;
        end else begin
            val = BITS_THD_DEF;
        end
        return val;
    endfunction

endpackage

// File: rtl/tone_quiet_mon.sv
// Counts consecutive quiet cycles and total enabled cycles for a pending commit.
// Hit flags are registered counts compared to the limits; counters saturate.
module tone_quiet_mon
    import tone_cfg_ctrl_pkg::*;
#(
    parameter int QUIET_CYC   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [NUM_CH-1:0] det_in,
    output logic              quiet_hit,
    output logic              timeout_hit
);

    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYC);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);

    logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        if (clear) begin
            quiet_cnt_d = '0;
            tmo_cnt_d   = '0;
        end else if (enable) begin
            // Any detector activity restarts the quiet window.
            if (det_in != '0) begin
                quiet_cnt_d = '0;
            end else if (quiet_cnt_q != QUIET_MAX) begin
                quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
            if (tmo_cnt_q != TMO_MAX) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quiet_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            quiet_cnt_q <= quiet_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign quiet_hit   = (quiet_cnt_q == QUIET_MAX);
    assign timeout_hit = (tmo_cnt_q == TMO_MAX);

endmodule

// File: rtl/tone_cfg_ctrl.sv
// Shadow/active threshold register bank with a quiet-gated atomic shadow->active commit.
// rd_data lags rd_addr by one cycle; commit_req is dropped (not queued) while busy.
module tone_cfg_ctrl
    import tone_cfg_ctrl_pkg::*;
#(
    parameter int QUIET_CYC   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  rd_addr,
    input  logic        rd_sel,
    output logic [15:0] rd_data,
    input  logic        commit_req,
    output logic        commit_ack,
    output logic        timeout_err,
    output logic        busy,
    input  logic [5:0]  det_in,
    output logic [95:0] thd_lev_bus,
    output logic [95:0] bits_thd_bus
);

    tone_state_e state_q, state_d;
    logic        abort_q, abort_d;
    logic        commit_ack_q, commit_ack_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [15:0] shadow_q [NUM_REGS];
    logic [15:0] shadow_d [NUM_REGS];
    logic [15:0] active_q [NUM_REGS];
    logic [15:0] active_d [NUM_REGS];

    logic apply_en;
    logic mon_clear;
    logic mon_enable;
    logic quiet_hit;
    logic timeout_hit;

    assign mon_clear  = (state_q == ST_IDLE);
    assign mon_enable = clk_enable && (state_q == ST_WAIT_QUIET);

    tone_quiet_mon #(
        .QUIET_CYC   (QUIET_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_quiet_mon (
        .clk         (clk),
        .reset       (reset),
        .clear       (mon_clear),
        .enable      (mon_enable),
        .det_in      (det_in),
        .quiet_hit   (quiet_hit),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        apply_en      = 1'b0;
        commit_ack_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clk_enable && commit_req) begin
                    state_d = ST_WAIT_QUIET;
                    abort_d = 1'b0;
                end
            end
            ST_WAIT_QUIET: begin
                // Quiet is tested first so it wins a tie with the timeout.
                if (clk_enable) begin
                    if (quiet_hit) begin
                        state_d = ST_APPLY;
                    end else if (timeout_hit) begin
                        state_d       = ST_ACK;
                        abort_d       = 1'b1;
                        commit_ack_d  = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            ST_APPLY: begin
                if (clk_enable) begin
                    state_d       = ST_ACK;
                    apply_en      = 1'b1;
                    commit_ack_d  = 1'b1;
                    timeout_err_d = abort_q;
                end
            end
            ST_ACK: begin
                if (clk_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Active copies the pre-edge shadow, so a write in the APPLY cycle stays in shadow only.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = apply_en ? shadow_q[i] : active_q[i];
            if (wr_en && (wr_addr < ADDR_RSVD_BASE) && (wr_addr == 4'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < ADDR_RSVD_BASE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr == 4'(i)) begin
                    rd_data_d = rd_sel ? active_q[i] : shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            abort_q       <= 1'b0;
            commit_ack_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            rd_data_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= reg_default(4'(i));
                active_q[i] <= reg_default(4'(i));
            end
        end else begin
            state_q       <= state_d;
            abort_q       <= abort_d;
            commit_ack_q  <= commit_ack_d;
            timeout_err_q <= timeout_err_d;
            rd_data_q     <= rd_data_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    always_comb begin
        thd_lev_bus  = '0;
        bits_thd_bus = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            thd_lev_bus[16*n +: 16]  = active_q[int'(ADDR_THD_LEV_BASE) + n];
            bits_thd_bus[16*n +: 16] = active_q[int'(ADDR_BITS_THD_BASE) + n];
        end
    end

    assign rd_data     = rd_data_q;
    assign commit_ack  = commit_ack_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_cfg_ctrl.sv
// Bench for tone_cfg_ctrl: vector table, directed commit sequences and a random scoreboard.
module tb_tone_cfg_ctrl;

    localparam int QUIET = 16;
    localparam int TMO   = 4096;
    localparam int MAXC  = 4300;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic        rd_sel;
    logic [15:0] rd_data;
    logic        commit_req;
    logic        commit_ack;
    logic        timeout_err;
    logic        busy;
    logic [5:0]  det_in;
    logic [95:0] thd_lev_bus;
    logic [95:0] bits_thd_bus;

    tone_cfg_ctrl #(.QUIET_CYC(QUIET), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .rd_data(rd_data), .commit_req(commit_req), .commit_ack(commit_ack),
        .timeout_err(timeout_err), .busy(busy), .det_in(det_in),
        .thd_lev_bus(thd_lev_bus), .bits_thd_bus(bits_thd_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_shadow [12];
    logic [15:0] m_active [12];

    bit       en_arr  [MAXC+1];
    bit [5:0] det_arr [MAXC+1];
    bit       cr_arr  [MAXC+1];
    int          wr_cyc;
    logic [3:0]  wr_a;
    logic [15:0] wr_d;

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra;
        logic        rs;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vt [12];

    function automatic logic [15:0] def_val(input int i);
        return (i == 2) ? 16'd250 : ((i < 6) ? 16'd300 : 16'd10);
    endfunction

    function automatic logic [15:0] model_rd(input logic [3:0] a, input logic s);
        if (a >= 4'd12) return 16'd0;
        return s ? m_active[a] : m_shadow[a];
    endfunction

    task automatic init_model();
        for (int i = 0; i < 12; i++) begin
            m_shadow[i] = def_val(i);
            m_active[i] = def_val(i);
        end
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: rd expectation from pre-edge model state, then shadow write lands.
    task automatic step(input bit check_rd);
        logic [15:0] e;
        e = model_rd(rd_addr, rd_sel);
        if (wr_en && wr_addr < 4'd12) m_shadow[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        if (check_rd) chk("rd_data", 96'(rd_data), 96'(e));
    endtask

    task automatic check_buses(input string tag);
        for (int n = 0; n < 6; n++) begin
            chk($sformatf("%s thd_lev_%0d", tag, n), 96'(thd_lev_bus[16*n +: 16]), 96'(m_active[n]));
            chk($sformatf("%s bits_thd_%0d", tag, n), 96'(bits_thd_bus[16*n +: 16]), 96'(m_active[6+n]));
        end
    endtask

    task automatic fill_plain();
        for (int c = 0; c <= MAXC; c++) begin
            en_arr[c]  = 1'b1;
            det_arr[c] = '0;
            cr_arr[c]  = 1'b0;
        end
        wr_cyc = -1;
        wr_a   = '0;
        wr_d   = '0;
    endtask

    // Expected ack cycle from the enabled-cycle sequence: 16 consecutive quiet enabled
    // cycles then two more enabled edges (APPLY, ACK); else timeout then one edge.
    function automatic void predict(input int limit, output int ack_c, output bit abort);
        int j = 0;
        int run = 0;
        int hit_j = 0;
        bit quiet = 1'b0;
        ack_c = -1;
        abort = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (en_arr[c]) begin
                j++;
                if (hit_j == 0) begin
                    run = (det_arr[c] == 0) ? run + 1 : 0;
                    if (run >= QUIET) begin
                        hit_j = j;
                        quiet = 1'b1;
                    end else if (j >= TMO) begin
                        hit_j = j;
                    end
                end else if (quiet && j == hit_j + 2) begin
                    ack_c = c;
                    break;
                end else if (!quiet && j == hit_j + 1) begin
                    ack_c = c;
                    abort = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic run_commit(input int limit, output int ack_c, output logic terr,
                              output int exp_ack, output bit exp_abort);
        predict(limit, exp_ack, exp_abort);
        commit_req = 1'b1; clk_enable = 1'b1; det_in = '0; wr_en = 1'b0;
        step(0);
        commit_req = 1'b0;
        ack_c = -1;
        terr  = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            clk_enable = en_arr[c];
            det_in     = det_arr[c];
            commit_req = cr_arr[c];
            wr_en      = (c == wr_cyc);
            wr_addr    = wr_a;
            wr_data    = wr_d;
            if (!exp_abort && c == exp_ack) m_active = m_shadow;
            step(0);
            if (commit_ack) begin
                ack_c = c;
                terr  = timeout_err;
                break;
            end
        end
        commit_req = 1'b0; wr_en = 1'b0; clk_enable = 1'b1; det_in = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ack_c, exp_ack, cnt;
        logic terr;
        bit exp_abort;

        vt[0]  = '{1'b1, 4'd3,  16'h1234, 4'd3,  1'b0, 16'd300};
        vt[1]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  1'b0, 16'h1234};
        vt[2]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  1'b1, 16'd300};
        vt[3]  = '{1'b1, 4'd12, 16'hBEEF, 4'd12, 1'b0, 16'd0};
        vt[4]  = '{1'b1, 4'd15, 16'hFFFF, 4'd15, 1'b1, 16'd0};
        vt[5]  = '{1'b1, 4'd11, 16'hFF9C, 4'd2,  1'b0, 16'd250};
        vt[6]  = '{1'b0, 4'd0,  16'h0000, 4'd11, 1'b0, 16'hFF9C};
        vt[7]  = '{1'b0, 4'd0,  16'h0000, 4'd11, 1'b1, 16'd10};
        vt[8]  = '{1'b0, 4'd0,  16'h0000, 4'd6,  1'b0, 16'd10};
        vt[9]  = '{1'b1, 4'd3,  16'd300,  4'd13, 1'b0, 16'd0};
        vt[10] = '{1'b1, 4'd11, 16'd10,   4'd3,  1'b0, 16'd300};
        vt[11] = '{1'b0, 4'd0,  16'h0000, 4'd11, 1'b0, 16'd10};

        reset = 1'b0; clk_enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; rd_sel = 1'b0; commit_req = 1'b0; det_in = '0;
        init_model();
        fill_plain();
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 96'(busy), 96'd0);
        chk("reset commit_ack", 96'(commit_ack), 96'd0);
        chk("reset timeout_err", 96'(timeout_err), 96'd0);
        chk("reset rd_data", 96'(rd_data), 96'd0);
        reset = 1'b1;
        step(0);
        for (int n = 0; n < 6; n++) begin
            chk($sformatf("reset thd_lev_%0d", n), 96'(thd_lev_bus[16*n +: 16]),
                (n == 2) ? 96'd250 : 96'd300);
            chk($sformatf("reset bits_thd_%0d", n), 96'(bits_thd_bus[16*n +: 16]), 96'd10);
        end

        for (int i = 0; i < 12; i++) begin
            wr_en = vt[i].wr; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_addr = vt[i].ra; rd_sel = vt[i].rs;
            step(0);
            chk($sformatf("vec%0d rd_data", i), 96'(rd_data), 96'(vt[i].exp_rd));
        end
        wr_en = 1'b0;

        // Quiet commit of thd_lev_0 = 500.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd500;
        step(0);
        wr_en = 1'b0;
        fill_plain();
        run_commit(100, ack_c, terr, exp_ack, exp_abort);
        chk("quiet ack cycle", 96'(ack_c), 96'd18);
        chk("quiet timeout_err", 96'(terr), 96'd0);
        chk("quiet thd_lev_0", 96'(thd_lev_bus[15:0]), 96'd500);
        step(0);
        chk("ack single pulse", 96'(commit_ack), 96'd0);
        step(0);
        chk("idle after ack", 96'(busy), 96'd0);

        // Detector activity every 10 cycles forces the timeout abort.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd777;
        step(0);
        wr_en = 1'b0;
        fill_plain();
        for (int c = 0; c <= MAXC; c++) det_arr[c] = (c % 10 == 0) ? 6'h04 : 6'h00;
        run_commit(TMO + 50, ack_c, terr, exp_ack, exp_abort);
        chk("timeout ack cycle", 96'(ack_c), 96'(TMO + 1));
        chk("timeout model agrees", 96'(exp_ack), 96'(TMO + 1));
        chk("timeout_err", 96'(terr), 96'd1);
        chk("timeout thd_lev_0 kept", 96'(thd_lev_bus[15:0]), 96'd500);
        check_buses("timeout");

        // Write to bits_thd_1 in the APPLY cycle.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'd55;
        step(0);
        wr_en = 1'b0;
        fill_plain();
        wr_cyc = 18; wr_a = 4'd7; wr_d = 16'd99;
        run_commit(100, ack_c, terr, exp_ack, exp_abort);
        chk("apply-write ack cycle", 96'(ack_c), 96'd18);
        chk("apply-write active bits_thd_1", 96'(bits_thd_bus[31:16]), 96'd55);
        rd_addr = 4'd7; rd_sel = 1'b0;
        step(1);
        chk("apply-write shadow rd 7", 96'(rd_data), 96'd99);
        rd_sel = 1'b1;
        step(1);

        // clk_enable low for 50 cycles in WAIT_QUIET plus an ignored second request.
        fill_plain();
        for (int c = 5; c < 55; c++) en_arr[c] = 1'b0;
        cr_arr[30] = 1'b1;
        run_commit(200, ack_c, terr, exp_ack, exp_abort);
        chk("stall ack cycle", 96'(ack_c), 96'd68);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(0);
            if (commit_ack) cnt++;
        end
        chk("no second commit", 96'(cnt), 96'd0);
        chk("stall busy idle", 96'(busy), 96'd0);
        check_buses("stall");

        // Random writes, reads and enables while idle, scored against the model.
        for (int k = 0; k < 200; k++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 16'($urandom);
            rd_addr    = 4'($urandom_range(0, 15));
            rd_sel     = 1'($urandom_range(0, 1));
            clk_enable = 1'($urandom_range(0, 1));
            det_in     = 6'($urandom);
            step(1);
        end
        wr_en = 1'b0;

        // Random commits with sporadic detector activity and clk_enable gaps.
        for (int r = 0; r < 3; r++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 11)); wr_data = 16'($urandom);
            step(0);
            wr_en = 1'b0;
            fill_plain();
            for (int c = 1; c <= 400; c++) begin
                en_arr[c]  = (c > 200) || ($urandom_range(0, 3) != 0);
                det_arr[c] = (c < 60 && $urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            end
            run_commit(400, ack_c, terr, exp_ack, exp_abort);
            chk($sformatf("rand%0d ack cycle", r), 96'(ack_c), 96'(exp_ack));
            chk($sformatf("rand%0d timeout_err", r), 96'(terr), 96'(exp_abort));
            step(0);
            check_buses($sformatf("rand%0d", r));
        end

        // Reset during WAIT_QUIET aborts silently.
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'd1234;
        step(0);
        wr_en = 1'b0;
        commit_req = 1'b1;
        step(0);
        commit_req = 1'b0;
        repeat (5) step(0);
        chk("mid-wait busy", 96'(busy), 96'd1);
        reset = 1'b0;
        #3;
        chk("async reset busy", 96'(busy), 96'd0);
        init_model();
        repeat (2) step(0);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(0);
            if (commit_ack) cnt++;
        end
        chk("reset no ack", 96'(cnt), 96'd0);
        check_buses("post-reset");
        rd_addr = 4'd4; rd_sel = 1'b0;
        step(1);
        chk("post-reset shadow 4", 96'(rd_data), 96'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
